mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single processor-to-memory port between three requesters: instruction fetch, FU load unit and retire store path. Each cycle it selects at most one request, drives proc2mem_*, and records the memory-returned tag with its owner. When the tag later comes back, it routes the returned data to the correct requester. It replaces the fixed-priority combinational mux at the pipeline top and adds fetch anti-starvation, flush squashing and an outstanding-request limit.

Parameters:
N_TAGS, 16, memory tag space; tag 0 means "request rejected".
MAX_OUTSTANDING, 8, maximum in-flight tagged (load-type) requests.
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  branch recovery (br_recover_enable); squashes in-flight FU loads
if_req_cmd  in  2  fetch command (BUS_NONE/BUS_LOAD)
if_req_addr  in  XLEN  fetch address
ld_req_cmd  in  2  FU load command (BUS_NONE/BUS_LOAD)
ld_req_addr  in  XLEN  FU load address
st_req_cmd  in  2  retire command (BUS_NONE/BUS_STORE/BUS_LOAD)
st_req_addr  in  XLEN  retire address
st_req_data  in  64  store data
if_accept, ld_accept, st_accept  out  1 each  request accepted this cycle (granted and response!=0)
if_rsp_valid, ld_rsp_valid, st_rsp_valid  out  1 each  data returned for that requester
rsp_data  out  64  returned data, common to all requesters (qualified by *_rsp_valid)
proc2mem_command  out  2  to memory
proc2mem_addr  out  XLEN  to memory
proc2mem_data  out  64  to memory
mem2proc_response  in  4  tag assigned this cycle; 0 means rejected
mem2proc_tag  in  4  tag of the data returning this cycle; 0 means none
mem2proc_data  in  64  returned data
outstanding_cnt  out  4  number of valid table entries (debug/verification)

Behaviour:
- Reset (synchronous, active-high): tag table cleared (all invalid); starvation counter 0; outstanding_cnt 0.
- Outputs with no requests, and during the reset cycle: proc2mem_command=BUS_NONE, addr/data 0, all accept/rsp_valid 0.
- Grant selection is combinational, same cycle as the request.
- Default priority: ld > st > if.
- If starve_cnt==STARVE_LIMIT and if_req_cmd!=BUS_NONE, fetch wins that cycle.
- Load-type requests (all of if, all of ld, st with BUS_LOAD) are ineligible while outstanding_cnt==MAX_OUTSTANDING. BUS_STORE remains eligible.
- proc2mem_* reflect the winner. proc2mem_data = st_req_data only when st wins, else 0.
- Accept = winner && mem2proc_response!=0. A rejected request gets no accept; the requester must hold its request.
- On accept of a load-type request: table[response] <= {valid=1, owner, squashed=0}. BUS_STORE accepts allocate nothing.
- starve_cnt: increments when a fetch request is present and not accepted; resets to 0 on fetch accept or when there is no fetch request; saturates at STARVE_LIMIT.
- Return handling: when mem2proc_tag!=0 and table[tag].valid, assert the owner's rsp_valid (suppressed if squashed), drive rsp_data=mem2proc_data, and clear the entry.
- A return whose tag has no valid entry is ignored.
- Return and re-allocation of the same tag in one cycle: clear first, then set. The entry ends valid with the new owner.
- outstanding_cnt = popcount(valid). Allocate and free in the same cycle leaves the count unchanged.
- flush: every valid entry with owner==ld gets squashed=1 (entry kept until its tag returns, so no misrouting).
- A ld request presented in the flush cycle is not granted.
- if and st entries are unaffected by flush.
- reset mid-operation: table cleared immediately. Later returns of stale tags are ignored.

Decomposition:
- Shared package gets: MEM_OWNER enum (OWN_IF, OWN_LD, OWN_ST), MEM_TAG_ENTRY struct {valid, owner, squashed}, plus the MAX_OUTSTANDING and STARVE_LIMIT defaults. BUS_* encodings are reused.
- One sub-module: mem_tag_table (tag-indexed owner table with alloc/free/squash ports and popcount).

Test Plan:
- ld_cmd=LOAD@0x100 and if_cmd=LOAD@0x40 together, response=3 -> ld_accept=1, proc2mem_addr=0x100, table[3]=ld. Later tag=3, data=0xDEAD -> ld_rsp_valid=1, rsp_data=0xDEAD.
- Fetch requesting while ld requests every cycle, response=5 each cycle -> fetch denied 4 cycles, 5th cycle if_accept=1.
- 8 ld loads accepted, no returns -> outstanding_cnt=8; next ld/if not granted; st BUS_STORE @0x200 still accepted with proc2mem_data=st_req_data.
- ld accepted tag 7, flush next cycle, tag 7 returns -> ld_rsp_valid=0, entry freed, outstanding_cnt decrements.
- Return tag 2 while a new if request receives response=2 in the same cycle -> the old owner's rsp_valid=1; table[2] now owner if; outstanding_cnt unchanged.
- response=0 for ld -> ld_accept=0, no allocation; reset with 3 outstanding -> count 0, a subsequent tag return produces no rsp_valid.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-to-memory port arbiter.
// Covers bus command encodings, tag owner identities and tag-table entries.
package mem_bus_arbiter_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned N_TAGS_DEF          = 16;
    localparam int unsigned MAX_OUTSTANDING_DEF = 8;
    localparam int unsigned STARVE_LIMIT_DEF    = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_LD = 2'd1,
        OWN_ST = 2'd2
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
        logic     squashed;
    } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_table.sv
// Tag-indexed owner table: records who issued each in-flight tagged request.
// Provides alloc/free/squash updates, a read port and a valid-entry popcount.
import mem_bus_arbiter_pkg::*;

module mem_tag_table #(
    parameter int unsigned N_TAGS = N_TAGS_DEF,
    parameter int unsigned TAG_W  = $clog2(N_TAGS),
    parameter int unsigned CNT_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash_ld,
    input  logic               free_en,
    input  logic [TAG_W-1:0]   free_tag,
    input  logic               alloc_en,
    input  logic [TAG_W-1:0]   alloc_tag,
    input  MEM_OWNER           alloc_owner,
    input  logic [TAG_W-1:0]   rd_tag,
    output MEM_TAG_ENTRY       rd_entry,
    output logic [CNT_W-1:0]   count
);

    MEM_TAG_ENTRY table_q [N_TAGS];

    // Later writes win: squash, then free, then alloc, so a same-cycle
    // return and reallocation of one tag ends with the new owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_TAGS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            if (squash_ld) begin
                for (int unsigned i = 0; i < N_TAGS; i++) begin
                    if (table_q[i].valid && table_q[i].owner == OWN_LD) begin
                        table_q[i].squashed <= 1'b1;
                    end
                end
            end
            if (free_en) begin
                table_q[free_tag].valid    <= 1'b0;
                table_q[free_tag].squashed <= 1'b0;
            end
            if (alloc_en) begin
                table_q[alloc_tag].valid    <= 1'b1;
                table_q[alloc_tag].owner    <= alloc_owner;
                table_q[alloc_tag].squashed <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_entry = table_q[rd_tag];
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N_TAGS; i++) begin
            count = count + CNT_W'(table_q[i].valid);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch, FU load and retire store onto the single memory port and
// routes returned tagged data back to the requester that owns the tag.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int unsigned N_TAGS          = N_TAGS_DEF,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       if_req_cmd,
    input  logic [XLEN-1:0]  if_req_addr,
    input  logic [1:0]       ld_req_cmd,
    input  logic [XLEN-1:0]  ld_req_addr,
    input  logic [1:0]       st_req_cmd,
    input  logic [XLEN-1:0]  st_req_addr,
    input  logic [63:0]      st_req_data,
    output logic             if_accept,
    output logic             ld_accept,
    output logic             st_accept,
    output logic             if_rsp_valid,
    output logic             ld_rsp_valid,
    output logic             st_rsp_valid,
    output logic [63:0]      rsp_data,
    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [3:0]       mem2proc_response,
    input  logic [3:0]       mem2proc_tag,
    input  logic [63:0]      mem2proc_data,
    output logic [3:0]       outstanding_cnt
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUTSTANDING);

    logic [STARVE_W-1:0] starve_cnt;
    logic                full;
    logic                if_req, if_elig, ld_elig, st_elig, st_is_store;
    logic                gnt_valid, accepted, alloc_en;
    MEM_OWNER            gnt_owner;
    MEM_TAG_ENTRY        rd_entry;
    logic                ret_hit;
    logic [3:0]          cnt;

    mem_tag_table #(
        .N_TAGS (N_TAGS),
        .TAG_W  (4),
        .CNT_W  (4)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .squash_ld   (flush),
        .free_en     (ret_hit),
        .free_tag    (mem2proc_tag),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (gnt_owner),
        .rd_tag      (mem2proc_tag),
        .rd_entry    (rd_entry),
        .count       (cnt)
    );

    assign outstanding_cnt = cnt;

    always_comb begin
        full        = (cnt >= MAX_OUT_C);
        st_is_store = (st_req_cmd == BUS_STORE);
        if_req      = (if_req_cmd != BUS_NONE);
        if_elig     = if_req && !full;
        ld_elig     = (ld_req_cmd != BUS_NONE) && !full && !flush;
        st_elig     = (st_req_cmd != BUS_NONE) && (st_is_store || !full);
    end

    // Fetch overrides the ld > st > if order once it has waited long enough.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_owner = OWN_IF;
        if (!reset) begin
            if (if_elig && starve_cnt == STARVE_MAX) begin
                gnt_valid = 1'b1;
                gnt_owner = OWN_IF;
            end else if (ld_elig) begin
                gnt_valid = 1'b1;
                gnt_owner = OWN_LD;
            end else if (st_elig) begin
                gnt_valid = 1'b1;
                gnt_owner = OWN_ST;
            end else if (if_elig) begin
                gnt_valid = 1'b1;
                gnt_owner = OWN_IF;
            end
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (gnt_valid) begin
            case (gnt_owner)
                OWN_IF: begin
                    proc2mem_command = if_req_cmd;
                    proc2mem_addr    = if_req_addr;
                end
                OWN_LD: begin
                    proc2mem_command = ld_req_cmd;
                    proc2mem_addr    = ld_req_addr;
                end
                default: begin
                    proc2mem_command = st_req_cmd;
                    proc2mem_addr    = st_req_addr;
                    proc2mem_data    = st_req_data;
                end
            endcase
        end
    end

    always_comb begin
        accepted  = gnt_valid && (mem2proc_response != '0);
        if_accept = accepted && (gnt_owner == OWN_IF);
        ld_accept = accepted && (gnt_owner == OWN_LD);
        st_accept = accepted && (gnt_owner == OWN_ST);
        alloc_en  = accepted && !(gnt_owner == OWN_ST && st_is_store);
    end

    // A load returning in the flush cycle is already dead, so it is dropped too.
    always_comb begin
        ret_hit      = !reset && (mem2proc_tag != '0) && rd_entry.valid;
        if_rsp_valid = ret_hit && !rd_entry.squashed && rd_entry.owner == OWN_IF;
        ld_rsp_valid = ret_hit && !rd_entry.squashed && rd_entry.owner == OWN_LD && !flush;
        st_rsp_valid = ret_hit && !rd_entry.squashed && rd_entry.owner == OWN_ST;
        rsp_data     = ret_hit ? mem2proc_data : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_accept) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cycles with a response scoreboard.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic              clock = 1'b0;
    logic              reset, flush;
    logic [1:0]        if_req_cmd, ld_req_cmd, st_req_cmd;
    logic [XLEN-1:0]   if_req_addr, ld_req_addr, st_req_addr;
    logic [63:0]       st_req_data;
    logic              if_accept, ld_accept, st_accept;
    logic              if_rsp_valid, ld_rsp_valid, st_rsp_valid;
    logic [63:0]       rsp_data;
    logic [1:0]        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [3:0]        mem2proc_response, mem2proc_tag;
    logic [63:0]       mem2proc_data;
    logic [3:0]        outstanding_cnt;

    mem_bus_arbiter #(
        .N_TAGS          (16),
        .MAX_OUTSTANDING (8),
        .STARVE_LIMIT    (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .if_req_cmd        (if_req_cmd),
        .if_req_addr       (if_req_addr),
        .ld_req_cmd        (ld_req_cmd),
        .ld_req_addr       (ld_req_addr),
        .st_req_cmd        (st_req_cmd),
        .st_req_addr       (st_req_addr),
        .st_req_data       (st_req_data),
        .if_accept         (if_accept),
        .ld_accept         (ld_accept),
        .st_accept         (st_accept),
        .if_rsp_valid      (if_rsp_valid),
        .ld_rsp_valid      (ld_rsp_valid),
        .st_rsp_valid      (st_rsp_valid),
        .rsp_data          (rsp_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .outstanding_cnt   (outstanding_cnt)
    );

    always #5 clock = ~clock;

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;

    typedef struct {
        logic [2:0]  rsp;
        logic [63:0] data;
    } rsp_exp_t;

    rsp_exp_t rsp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        reset             = 1'b0;
        flush             = 1'b0;
        if_req_cmd        = BUS_NONE;
        if_req_addr       = '0;
        ld_req_cmd        = BUS_NONE;
        ld_req_addr       = '0;
        st_req_cmd        = BUS_NONE;
        st_req_addr       = '0;
        st_req_data       = '0;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
        mem2proc_data     = '0;
    endtask

    task automatic ld_req(input logic [XLEN-1:0] a, input logic [3:0] resp);
        ld_req_cmd        = BUS_LOAD;
        ld_req_addr       = a;
        mem2proc_response = resp;
    endtask

    task automatic ret(input logic [3:0] t, input logic [63:0] d);
        mem2proc_tag  = t;
        mem2proc_data = d;
    endtask

    // Inputs are already driven; expectations go on the scoreboard, the DUT is
    // sampled at the falling edge, then the rising edge commits state.
    task automatic step(input string tag, input logic [2:0] exp_acc, input logic [1:0] exp_cmd,
                        input logic [XLEN-1:0] exp_addr, input logic [63:0] exp_pdata,
                        input logic [2:0] exp_rsp, input logic [63:0] exp_rdata);
        rsp_exp_t e;
        e.rsp  = exp_rsp;
        e.data = exp_rdata;
        rsp_q.push_back(e);
        @(negedge clock);
        check_eq({tag, ".acc"},   {if_accept, ld_accept, st_accept}, exp_acc);
        check_eq({tag, ".cmd"},   proc2mem_command, exp_cmd);
        check_eq({tag, ".addr"},  proc2mem_addr, exp_addr);
        check_eq({tag, ".pdata"}, proc2mem_data, exp_pdata);
        e = rsp_q.pop_front();
        check_eq({tag, ".rsp"}, {if_rsp_valid, ld_rsp_valid, st_rsp_valid}, e.rsp);
        if (e.rsp != 3'b000) check_eq({tag, ".rdata"}, rsp_data, e.data);
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        ld_req(32'h100, 4'd1);
        step("rst", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);
        check_eq("rst.cnt", outstanding_cnt, 4'd0);

        // ld beats if; tag 3 routed back to ld
        ld_req(32'h100, 4'd3);
        if_req_cmd = BUS_LOAD; if_req_addr = 32'h40;
        step("t1_gnt", 3'b010, BUS_LOAD, 32'h100, '0, 3'b000, '0);
        check_eq("t1_cnt", outstanding_cnt, 4'd1);
        ret(4'd3, 64'hDEAD);
        step("t1_ret", 3'b000, BUS_NONE, '0, '0, 3'b010, 64'hDEAD);
        check_eq("t1_cnt0", outstanding_cnt, 4'd0);

        // fetch starvation: four denials, then fetch wins
        for (int i = 0; i < 5; i++) begin
            ld_req(32'h100, 4'd5);
            if_req_cmd = BUS_LOAD; if_req_addr = 32'h40;
            if (i < 4) step("t2_deny", 3'b010, BUS_LOAD, 32'h100, '0, 3'b000, '0);
            else       step("t2_win",  3'b100, BUS_LOAD, 32'h40,  '0, 3'b000, '0);
        end
        check_eq("t2_cnt", outstanding_cnt, 4'd1);
        ret(4'd5, 64'h55);
        step("t2_ret", 3'b000, BUS_NONE, '0, '0, 3'b100, 64'h55);

        // outstanding limit
        for (int i = 1; i <= 8; i++) begin
            ld_req(32'h1000 + 32'(i) * 8, 4'(i));
            step("t3_fill", 3'b010, BUS_LOAD, 32'h1000 + 32'(i) * 8, '0, 3'b000, '0);
        end
        check_eq("t3_full", outstanding_cnt, 4'd8);
        ld_req(32'h100, 4'd9);
        if_req_cmd = BUS_LOAD; if_req_addr = 32'h40;
        step("t3_block", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);
        ld_req(32'h100, 4'd9);
        if_req_cmd = BUS_LOAD; if_req_addr = 32'h40;
        st_req_cmd = BUS_STORE; st_req_addr = 32'h200; st_req_data = 64'hCAFE_F00D;
        step("t3_store", 3'b001, BUS_STORE, 32'h200, 64'hCAFE_F00D, 3'b000, '0);
        check_eq("t3_cnt_st", outstanding_cnt, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            ret(4'(i), 64'(i) * 64'h111);
            step("t3_drain", 3'b000, BUS_NONE, '0, '0, 3'b010, 64'(i) * 64'h111);
        end
        check_eq("t3_cnt0", outstanding_cnt, 4'd0);

        // retire load path gets its own response
        st_req_cmd = BUS_LOAD; st_req_addr = 32'h300; st_req_data = 64'h77;
        mem2proc_response = 4'd13;
        step("t3_stld", 3'b001, BUS_LOAD, 32'h300, 64'h77, 3'b000, '0);
        ret(4'd13, 64'h1313);
        step("t3_stret", 3'b000, BUS_NONE, '0, '0, 3'b001, 64'h1313);

        // flush squashes ld entries only
        if_req_cmd = BUS_LOAD; if_req_addr = 32'h40; mem2proc_response = 4'd4;
        step("t4_if", 3'b100, BUS_LOAD, 32'h40, '0, 3'b000, '0);
        ld_req(32'h180, 4'd7);
        step("t4_ld", 3'b010, BUS_LOAD, 32'h180, '0, 3'b000, '0);
        check_eq("t4_cnt2", outstanding_cnt, 4'd2);
        flush = 1'b1;
        ld_req(32'h190, 4'd6);
        step("t4_flush", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);
        check_eq("t4_cnt_fl", outstanding_cnt, 4'd2);
        ret(4'd7, 64'h77);
        step("t4_sq", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);
        check_eq("t4_cnt1", outstanding_cnt, 4'd1);
        ret(4'd4, 64'h44);
        step("t4_ifret", 3'b000, BUS_NONE, '0, '0, 3'b100, 64'h44);
        check_eq("t4_cnt0", outstanding_cnt, 4'd0);

        // same tag freed and reallocated in one cycle
        ld_req(32'h1C0, 4'd2);
        step("t5_ld", 3'b010, BUS_LOAD, 32'h1C0, '0, 3'b000, '0);
        ret(4'd2, 64'hBEEF);
        if_req_cmd = BUS_LOAD; if_req_addr = 32'h40; mem2proc_response = 4'd2;
        step("t5_swap", 3'b100, BUS_LOAD, 32'h40, '0, 3'b010, 64'hBEEF);
        check_eq("t5_cnt", outstanding_cnt, 4'd1);
        ret(4'd2, 64'h22);
        step("t5_ifret", 3'b000, BUS_NONE, '0, '0, 3'b100, 64'h22);

        // rejected request
        ld_req(32'h1A0, 4'd0);
        step("t6_rej", 3'b000, BUS_LOAD, 32'h1A0, '0, 3'b000, '0);
        check_eq("t6_cnt", outstanding_cnt, 4'd0);

        // reset with three outstanding
        ld_req(32'h100, 4'd10);
        step("t7_a", 3'b010, BUS_LOAD, 32'h100, '0, 3'b000, '0);
        st_req_cmd = BUS_LOAD; st_req_addr = 32'h300; mem2proc_response = 4'd11;
        step("t7_b", 3'b001, BUS_LOAD, 32'h300, '0, 3'b000, '0);
        if_req_cmd = BUS_LOAD; if_req_addr = 32'h44; mem2proc_response = 4'd12;
        step("t7_c", 3'b100, BUS_LOAD, 32'h44, '0, 3'b000, '0);
        check_eq("t7_cnt3", outstanding_cnt, 4'd3);
        reset = 1'b1;
        ld_req(32'h100, 4'd1);
        ret(4'd10, 64'h10);
        step("t7_rst", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);
        check_eq("t7_cnt0", outstanding_cnt, 4'd0);
        ret(4'd10, 64'h10);
        step("t7_stale", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);
        ret(4'd12, 64'h12);
        step("t7_stale2", 3'b000, BUS_NONE, '0, '0, 3'b000, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
